// File: rtl/shift_ring_counter_pkg.sv
// Shared constants for the shift/ring counter slice.
package shift_ring_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    localparam logic DIR_UP = 1'b0;   // shift toward MSB
    localparam logic DIR_DN = 1'b1;   // shift toward LSB

endpackage

// File: rtl/shift_ring_counter_if.sv
// Control/status bundle between a sequencer master and the shift counter.
interface shift_ring_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             fault;

    modport master (
        output en, mode, dir, load, load_val,
        input  out, wrap, fault
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output out, wrap, fault
    );

endinterface

// File: rtl/shift_ring_counter_legal_chk.sv
// Judges whether a counter state is one of the legal states of the given mode.
// Ring: exactly one bit set. Johnson: at most one adjacent-bit transition.
module shift_ring_legal_chk
    import shift_ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  logic             mode,
    output logic             legal
);

    logic w_ring_one;
    logic w_ring_many;
    logic w_john_one;
    logic w_john_many;

    // Scan the bits once per mode, tracking "seen one" and "seen more than one".
    always_comb begin
        w_ring_one  = 1'b0;
        w_ring_many = 1'b0;
        w_john_one  = 1'b0;
        w_john_many = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (state[i]) begin
                if (w_ring_one) w_ring_many = 1'b1;
                w_ring_one = 1'b1;
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (state[i] != state[i+1]) begin
                if (w_john_one) w_john_many = 1'b1;
                w_john_one = 1'b1;
            end
        end
    end

    assign legal = (mode == MODE_JOHNSON) ? ~w_john_many
                                          : (w_ring_one & ~w_ring_many);

endmodule

// File: rtl/shift_ring_counter.sv
// Ring / Johnson shift counter used as a multi-phase sequencer.
// State, wrap and fault share one register so every output is registered.
module shift_ring_counter
    import shift_ring_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(1),
    parameter bit               SELF_CORRECT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    shift_ring_counter_if.slave bus
);

    // r_q = {fault, wrap, out}
    logic [WIDTH+1:0] r_q;
    logic [WIDTH+1:0] w_d;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_nxt;
    logic             w_legal;

    assign w_out = r_q[WIDTH-1:0];

    shift_ring_legal_chk #(
        .WIDTH (WIDTH)
    ) u_legal_chk (
        .state (w_out),
        .mode  (bus.mode),
        .legal (w_legal)
    );

    // Shifted candidate for the next step; Johnson feeds back the inverted end bit.
    always_comb begin
        w_nxt = w_out;
        case ({bus.mode, bus.dir})
            {MODE_RING,    DIR_UP}: w_nxt = {w_out[WIDTH-2:0],  w_out[WIDTH-1]};
            {MODE_RING,    DIR_DN}: w_nxt = { w_out[0],         w_out[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_UP}: w_nxt = {w_out[WIDTH-2:0], ~w_out[WIDTH-1]};
            {MODE_JOHNSON, DIR_DN}: w_nxt = {~w_out[0],         w_out[WIDTH-1:1]};
            default:                w_nxt = w_out;
        endcase
    end

    // Next register value: load beats step beats hold; pulses clear unless set this cycle.
    always_comb begin
        w_d = {2'b00, w_out};
        if (bus.load) begin
            w_d = {2'b00, bus.load_val};
        end else if (bus.en) begin
            if (SELF_CORRECT && !w_legal) begin
                w_d = {1'b1, 1'b0, SEED};
            end else begin
                w_d = {1'b0, (w_nxt == SEED), w_nxt};
            end
        end
    end

    // State register with asynchronous clear to SEED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= {2'b00, SEED};
        end else begin
            r_q <= w_d;
        end
    end

    assign bus.out   = r_q[WIDTH-1:0];
    assign bus.wrap  = r_q[WIDTH];
    assign bus.fault = r_q[WIDTH+1];

endmodule

// File: tb/tb_shift_ring_counter.sv
// Bench for shift_ring_counter: behavioural model checked every cycle, plus
// directed literal expectations on both the DUT and the model.
module tb_shift_ring_counter;

    localparam int         W    = 4;
    localparam logic [3:0] SEED = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_ring_counter_if #(.WIDTH(W)) bus ();

    shift_ring_counter #(
        .WIDTH        (W),
        .SEED         (SEED),
        .SELF_CORRECT (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // ---------------- behavioural model ----------------
    logic [3:0] m_out   = 4'b0000;
    logic       m_wrap  = 1'b0;
    logic       m_fault = 1'b0;
    logic       m_valid = 1'b0;

    function automatic logic is_legal(input logic [3:0] s, input logic mode);
        logic ok;
        ok = 1'b0;
        if (mode == 1'b0) begin
            ok = (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
        end else begin
            // legal Johnson states: k ones packed at the LSB end or at the MSB end
            for (int k = 0; k <= W; k++) begin
                logic [3:0] low;
                low = 4'((5'd1 << k) - 5'd1);
                if (s == low || s == (4'hF ^ low)) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [3:0] step_of(input logic [3:0] s, input logic mode, input logic d);
        logic [3:0] r;
        if (mode == 1'b0 && d == 1'b0)      r = 4'(((s << 1) | (s >> 3)) & 4'hF);
        else if (mode == 1'b0)              r = 4'((s >> 1) | ((s & 4'd1) << 3));
        else if (d == 1'b0)                 r = 4'((s << 1) & 4'hF) | (s[3] ? 4'd0 : 4'd1);
        else                                r = (s >> 1) | (s[0] ? 4'd0 : 4'd8);
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out   <= SEED;
            m_wrap  <= 1'b0;
            m_fault <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (bus.load) begin
                m_out   <= bus.load_val;
                m_wrap  <= 1'b0;
                m_fault <= 1'b0;
            end else if (bus.en) begin
                if (!is_legal(m_out, bus.mode)) begin
                    m_out   <= SEED;
                    m_wrap  <= 1'b0;
                    m_fault <= 1'b1;
                end else begin
                    m_out   <= step_of(m_out, bus.mode, bus.dir);
                    m_wrap  <= (step_of(m_out, bus.mode, bus.dir) == SEED);
                    m_fault <= 1'b0;
                end
            end else begin
                m_wrap  <= 1'b0;
                m_fault <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name,
                       input logic [3:0] ao, input logic aw, input logic af,
                       input logic [3:0] eo, input logic ew, input logic ef);
        checks++;
        if ({ao, aw, af} === {eo, ew, ef}) begin
            passes++;
        end else begin
            $display("FAIL %s: got out=%b wrap=%b fault=%b, expected out=%b wrap=%b fault=%b (t=%0t)",
                     name, ao, aw, af, eo, ew, ef, $time);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] eo, input logic ew, input logic ef);
        chk(name, bus.out, bus.wrap, bus.fault, eo, ew, ef);
        chk({"model_", name}, m_out, m_wrap, m_fault, eo, ew, ef);
    endtask

    task automatic cyc(input logic e, input logic m, input logic d,
                       input logic l, input logic [3:0] lv);
        bus.en       = e;
        bus.mode     = m;
        bus.dir      = d;
        bus.load     = l;
        bus.load_val = lv;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ring_up [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_up [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        bus.en       = 1'b0;
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'b0000;

        fork
            forever begin
                @(negedge clk);
                if (m_valid)
                    chk("cycle", bus.out, bus.wrap, bus.fault, m_out, m_wrap, m_fault);
            end
        join_none

        // 1: asynchronous reset mid-cycle, then hold
        #7 rst = 1'b0;
        #1 lit("reset_async", 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
            lit("hold", 4'b0001, 1'b0, 1'b0);
        end

        // 2: ring up
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
            lit("ring_up", ring_up[i], (i == 3), 1'b0);
        end

        // 3: Johnson up 8 steps, then down 2
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
            lit("john_up", john_up[i], (i == 7), 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        lit("john_dn0", 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        lit("john_dn1", 4'b1000, 1'b0, 1'b0);

        // 4: load beats enable, then ring step corrects the illegal value
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
        lit("load_wins", 4'b0110, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        lit("ring_correct", 4'b0001, 1'b0, 1'b1);

        // ring down, load of SEED without wrap, illegal load held while idle
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        lit("ring_dn", 4'b1000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        lit("load_seed_nowrap", 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
        lit("load_illegal", 4'b1010, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        lit("illegal_held", 4'b1010, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        lit("john_correct", 4'b0001, 1'b0, 1'b1);

        // 5: mode switch judges legality in the new mode
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0111);
        lit("load_0111", 4'b0111, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        lit("switch_ring_fault", 4'b0001, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        lit("load_zero", 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        lit("john_zero_step", 4'b0001, 1'b1, 1'b0);

        // 6: reset mid-sequence with a step pending
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        lit("ring_a", 4'b0010, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        lit("ring_b", 4'b0100, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1 lit("reset_mid", 4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        #1 lit("reset_held", 4'b0001, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        lit("after_release", 4'b0010, 1'b0, 1'b0);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
